// File: rtl/hazard_pkg.sv
// Purpose: shared ISA field constants, state encoding and source-operand record for the hazard logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

  // Opcodes (instruction bits [31:27])
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  // R-type ALU ops (instruction bits [6:2]) that go to the multdiv unit
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // Register that bex tests
  localparam logic [4:0] REG_STATUS = 5'd30;

  // Interlock FSM encoding
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_MD_BUSY = 1'b1;

  localparam logic [31:0] NOP = 32'd0;

  // Source registers an instruction reads in D, each with a valid bit
  typedef struct packed {
    logic [4:0] srcA;
    logic       srcAValid;
    logic [4:0] srcB;
    logic       srcBValid;
  } srcSel_t;

  function automatic logic [4:0] opcodeOf(input logic [31:0] ir);
    return ir[31:27];
  endfunction

  function automatic logic [4:0] rdOf(input logic [31:0] ir);
    return ir[26:22];
  endfunction

  function automatic logic [4:0] rsOf(input logic [31:0] ir);
    return ir[21:17];
  endfunction

  function automatic logic [4:0] rtOf(input logic [31:0] ir);
    return ir[16:12];
  endfunction

  function automatic logic [4:0] aluOpOf(input logic [31:0] ir);
    return ir[6:2];
  endfunction

endpackage

// File: rtl/hazard_src_decode.sv
// Purpose: map an instruction to the registers it reads (srcA/srcB + valid); r0 is never reported valid.
// Latency: combinational.
// Backpressure: none.
// Ports: ir (instruction in) -> srcA/srcAValid, srcB/srcBValid.
module hazard_src_decode
  import hazard_pkg::*;
(
  input  logic [31:0] ir,
  output logic [4:0]  srcA,
  output logic        srcAValid,
  output logic [4:0]  srcB,
  output logic        srcBValid
);

  logic       rawAValid;
  logic       rawBValid;
  logic [11:0] unusedBits;

  // Immediate / shamt / ALU-op bits do not name registers
  assign unusedBits = ir[11:0];

  always_comb begin
    srcA      = 5'd0;
    rawAValid = 1'b0;
    srcB      = 5'd0;
    rawBValid = 1'b0;
    case (opcodeOf(ir))
      OP_RTYPE: begin
        srcA = rsOf(ir); rawAValid = 1'b1;
        srcB = rtOf(ir); rawBValid = 1'b1;
      end
      // sw data (rd) is bypassed through dmem, so only the base register counts
      OP_ADDI, OP_LW, OP_SW: begin
        srcA = rsOf(ir); rawAValid = 1'b1;
      end
      // branches compare rd against rs
      OP_BNE, OP_BLT: begin
        srcA = rdOf(ir); rawAValid = 1'b1;
        srcB = rsOf(ir); rawBValid = 1'b1;
      end
      OP_JR: begin
        srcA = rdOf(ir); rawAValid = 1'b1;
      end
      OP_BEX: begin
        srcA = REG_STATUS; rawAValid = 1'b1;
      end
      default: ;  // j, jal, setx and unknown read nothing
    endcase
  end

  assign srcAValid = rawAValid && (srcA != 5'd0);
  assign srcBValid = rawBValid && (srcB != 5'd0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Purpose: pipeline interlock - load-use bubble, multdiv stall with timeout, taken-branch flush, stall counter.
// Latency: all controls combinational from current IRs/state; state, timer and counter update on clock.
// Backpressure: stalls PC/F/D (fd_en) and D/X (dx_en); multdiv stall holds X and bubbles X/M until md_ready or timeout.
// Ports: clock, reset (async active-low); fd_ir/dx_ir, branch_taken, md_ready in;
//        fd_en, dx_en, dx_bubble, xm_bubble, flush, md_start, md_busy, md_timeout, stall_count out.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      fd_ir,
  input  logic [31:0]      dx_ir,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic             fd_en,
  output logic             dx_en,
  output logic             dx_bubble,
  output logic             xm_bubble,
  output logic             flush,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TIMER_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MD_TIMEOUT - 1);

  logic [0:0]         state;
  logic [TIMER_W-1:0] mdTimer;

  logic [4:0] srcA;
  logic       srcAValid;
  logic [4:0] srcB;
  logic       srcBValid;

  logic dxIsMd;
  logic loadUse;
  logic mdRelease;
  logic mdStall;
  logic timeoutHit;

  logic [21:0] unusedBits;
  assign unusedBits = {dx_ir[21:7], dx_ir[1:0], 5'd0};

  hazard_src_decode uSrcDecode (
    .ir        (fd_ir),
    .srcA      (srcA),
    .srcAValid (srcAValid),
    .srcB      (srcB),
    .srcBValid (srcBValid)
  );

  assign dxIsMd = (opcodeOf(dx_ir) == OP_RTYPE) &&
                  ((aluOpOf(dx_ir) == ALU_MUL) || (aluOpOf(dx_ir) == ALU_DIV));

  assign loadUse = (opcodeOf(dx_ir) == OP_LW) && (rdOf(dx_ir) != 5'd0) &&
                   ((srcAValid && (srcA == rdOf(dx_ir))) ||
                    (srcBValid && (srcB == rdOf(dx_ir))));

  assign md_busy    = (state == ST_MD_BUSY);
  // md_ready wins over the timeout when both land on the last cycle
  assign timeoutHit = md_busy && !md_ready && (mdTimer == TIMER_LAST);
  assign mdRelease  = md_busy && (md_ready || timeoutHit);
  // start only from IDLE so back-to-back mul/div each get one pulse
  assign md_start   = (state == ST_IDLE) && dxIsMd;
  assign mdStall    = md_start || (md_busy && !mdRelease);
  assign md_timeout = timeoutHit;

  always_comb begin
    fd_en     = 1'b1;
    dx_en     = 1'b1;
    dx_bubble = 1'b0;
    xm_bubble = 1'b0;
    flush     = 1'b0;
    if (mdStall) begin
      fd_en     = 1'b0;
      dx_en     = 1'b0;
      xm_bubble = 1'b1;
    end else if (branch_taken) begin
      // the dependent instruction gets squashed, so no load-use bubble needed
      flush = 1'b1;
    end else if (loadUse) begin
      // one bubble: next cycle the lw is in M and the bypass covers it
      fd_en     = 1'b0;
      dx_bubble = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      mdTimer <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dxIsMd) begin
            state   <= ST_MD_BUSY;
            mdTimer <= '0;
          end
        end
        default: begin
          if (mdRelease) begin
            state   <= ST_IDLE;
            mdTimer <= '0;
          end else begin
            mdTimer <= mdTimer + TIMER_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (!fd_en && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Purpose: randomized + directed scoreboard bench for hazard_stall_unit against a rule-level reference model.
// Latency: expectations are pushed per cycle at posedge+1 and popped/compared at the following negedge.
// Backpressure: the bench's own pipeline honours the expected enables/bubbles/flush when advancing IRs.
module tb_hazard_stall_unit;

  localparam int T      = 8;
  localparam int CW     = 4;
  localparam int CNTMAX = (1 << CW) - 1;
  localparam logic [31:0] NOP_I = 32'd0;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   fd_ir = '0;
  logic [31:0]   dx_ir = '0;
  logic          branch_taken = 1'b0;
  logic          md_ready = 1'b0;
  logic          fd_en, dx_en, dx_bubble, xm_bubble, flush;
  logic          md_start, md_busy, md_timeout;
  logic [CW-1:0] stall_count;

  always #5 clock = ~clock;

  hazard_stall_unit #(.MD_TIMEOUT(T), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .fd_en(fd_en), .dx_en(dx_en), .dx_bubble(dx_bubble), .xm_bubble(xm_bubble),
    .flush(flush), .md_start(md_start), .md_busy(md_busy), .md_timeout(md_timeout),
    .stall_count(stall_count)
  );

  typedef struct {
    bit fdEn, dxEn, dxBub, xmBub, flush, mdStart, mdBusy, mdTo;
    int cnt;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  bit driverDone = 0;

  // reference model state
  bit mBusy  = 0;
  int mStart = 0;
  int mCnt   = 0;
  int cyc    = 0;
  int timeouts = 0;
  int mdStarts = 0;

  // Instruction builders
  function automatic logic [31:0] rtype(int rd, int rs, int rt, int alu);
    return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'b00};
  endfunction
  function automatic logic [31:0] itype(int op, int rd, int rs);
    return {5'(op), 5'(rd), 5'(rs), 17'd0};
  endfunction

  // Does instruction ir read register r in D (for interlock purposes)?
  function automatic bit readsReg(logic [31:0] ir, int r);
    int op, rd, rs, rt;
    op = int'(ir[31:27]); rd = int'(ir[26:22]); rs = int'(ir[21:17]); rt = int'(ir[16:12]);
    if (r == 0) return 0;
    case (op)
      0:        return (rs == r) || (rt == r);          // R-type
      5, 8, 7:  return (rs == r);                       // addi, lw, sw (base only)
      2, 6:     return (rd == r) || (rs == r);          // bne, blt
      4:        return (rd == r);                       // jr
      22:       return (r == 30);                       // bex
      default:  return 0;                               // j, jal, setx
    endcase
  endfunction

  function automatic bit isMd(logic [31:0] ir);
    return (ir[31:27] == 5'd0) && ((ir[6:2] == 5'd6) || (ir[6:2] == 5'd7));
  endfunction

  function automatic bit isLoadUse(logic [31:0] dx, logic [31:0] fd);
    return (dx[31:27] == 5'd8) && (dx[26:22] != 5'd0) && readsReg(fd, int'(dx[26:22]));
  endfunction

  function automatic int pickReg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 30 : r;
  endfunction

  function automatic logic [31:0] randInstr();
    int ops[11] = '{0, 5, 7, 8, 1, 2, 3, 4, 6, 21, 22};
    int alus[4] = '{0, 1, 6, 7};
    int op;
    op = ops[$urandom_range(0, 10)];
    if (op == 0) return rtype(pickReg(), pickReg(), pickReg(), alus[$urandom_range(0, 3)]);
    return itype(op, pickReg(), pickReg());
  endfunction

  task automatic chk(string name, int act, int expv, int c);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, expv);
    end
  endtask

  // Drive one cycle of inputs and push the model's expected response
  task automatic step(input logic [31:0] fd, input logic [31:0] dx,
                      input bit br, input bit rdy, input bit rstn, output exp_t e);
    bit dxMd, rel, stallMd, lu;
    int elapsed;
    @(posedge clock);
    #1;
    reset = rstn; fd_ir = fd; dx_ir = dx; branch_taken = br; md_ready = rdy;
    if (!rstn) begin mBusy = 0; mCnt = 0; end
    dxMd    = isMd(dx);
    lu      = isLoadUse(dx, fd);
    elapsed = cyc - mStart;               // cycles since the start pulse
    rel     = mBusy && (rdy || elapsed == T);
    stallMd = (!mBusy && dxMd) || (mBusy && !rel);
    e = '{fdEn: 1, dxEn: 1, dxBub: 0, xmBub: 0, flush: 0, mdStart: 0, mdBusy: 0, mdTo: 0,
          cnt: mCnt, cyc: cyc};
    e.mdStart = !mBusy && dxMd;
    e.mdBusy  = mBusy;
    e.mdTo    = mBusy && !rdy && (elapsed == T);
    if (stallMd) begin
      e.fdEn = 0; e.dxEn = 0; e.xmBub = 1;
    end else if (br) begin
      e.flush = 1;
    end else if (lu) begin
      e.fdEn = 0; e.dxBub = 1;
    end
    sbq.push_back(e);
    if (e.mdTo) timeouts++;
    if (e.mdStart) mdStarts++;
    if (rstn) begin
      if (!mBusy && dxMd) begin mBusy = 1; mStart = cyc; end
      else if (rel) mBusy = 0;
      if (!e.fdEn && mCnt < CNTMAX) mCnt++;
    end
    cyc++;
  endtask

  // Monitor: pop and compare every cycle an expectation is outstanding
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("fd_en",       int'(fd_en),       int'(e.fdEn),    e.cyc);
        chk("dx_en",       int'(dx_en),       int'(e.dxEn),    e.cyc);
        chk("dx_bubble",   int'(dx_bubble),   int'(e.dxBub),   e.cyc);
        chk("xm_bubble",   int'(xm_bubble),   int'(e.xmBub),   e.cyc);
        chk("flush",       int'(flush),       int'(e.flush),   e.cyc);
        chk("md_start",    int'(md_start),    int'(e.mdStart), e.cyc);
        chk("md_busy",     int'(md_busy),     int'(e.mdBusy),  e.cyc);
        chk("md_timeout",  int'(md_timeout),  int'(e.mdTo),    e.cyc);
        chk("stall_count", int'(stall_count), e.cnt,           e.cyc);
      end
    end
  end

  initial begin
    exp_t e;
    logic [31:0] lwR3, addDep, mul, pipeFd, pipeDx;
    int toBefore, startsBefore;
    bit rstn, br, rdy;

    lwR3   = itype(8, 3, 1);          // lw r3,0(r1)
    addDep = rtype(4, 3, 2, 0);       // add r4,r3,r2
    mul    = rtype(5, 1, 2, 6);       // mul r5,r1,r2

    // reset state
    step(NOP_I, NOP_I, 0, 0, 0, e);
    step(NOP_I, NOP_I, 0, 0, 0, e);

    // load-use: exactly one bubble, then clear
    step(addDep, lwR3, 0, 0, 1, e);
    step(addDep, NOP_I, 0, 0, 1, e);
    // no false stalls: sw data reg, lw to r0; real stall on sw base
    step(itype(7, 3, 5), lwR3, 0, 0, 1, e);
    step(itype(7, 6, 3), lwR3, 0, 0, 1, e);
    step(rtype(4, 0, 0, 0), itype(8, 0, 1), 0, 0, 1, e);
    step(itype(22, 0, 0), itype(8, 30, 1), 0, 0, 1, e);   // bex vs lw r30

    // multiply, ready 5 cycles after start
    for (int i = 0; i < 5; i++) step(addDep, mul, 0, 0, 1, e);
    step(addDep, mul, 0, 1, 1, e);
    step(addDep, NOP_I, 0, 0, 1, e);

    // timeout with md_ready held low
    toBefore = timeouts;
    for (int i = 0; i <= T; i++) step(NOP_I, mul, 0, 0, 1, e);
    step(NOP_I, NOP_I, 0, 0, 1, e);
    chk("timeout_pulse_count", timeouts - toBefore, 1, cyc);

    // branch taken beats load-use
    step(addDep, lwR3, 1, 0, 1, e);

    // reset mid MD_BUSY
    toBefore = timeouts;
    for (int i = 0; i < 3; i++) step(NOP_I, mul, 0, 0, 1, e);
    step(NOP_I, NOP_I, 0, 0, 0, e);
    for (int i = 0; i < T + 2; i++) step(NOP_I, NOP_I, 0, 0, 1, e);
    chk("reset_abort_no_timeout", timeouts - toBefore, 0, cyc);

    // saturation: 20 consecutive stall cycles
    for (int i = 0; i < 20; i++) step(addDep, lwR3, 0, 0, 1, e);
    step(NOP_I, NOP_I, 0, 0, 1, e);

    // randomized pipeline run
    pipeFd = NOP_I; pipeDx = NOP_I;
    startsBefore = mdStarts;
    for (int i = 0; i < 3000; i++) begin
      rstn = ($urandom_range(0, 59) != 0);
      br   = ($urandom_range(0, 7) == 0);
      rdy  = ($urandom_range(0, 4) == 0);
      step(pipeFd, pipeDx, br, rdy, rstn, e);
      if (e.flush) begin
        pipeFd = NOP_I; pipeDx = NOP_I;
      end else begin
        if (e.dxEn) pipeDx = e.dxBub ? NOP_I : pipeFd;
        if (e.fdEn) pipeFd = randInstr();
      end
    end
    if (mdStarts == startsBefore) begin
      errors++;
      $display("FAIL random_md_coverage: got 0 md starts, expected at least 1");
    end

    driverDone = 1;
    repeat (3) @(posedge clock);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL time_limit: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks);
    $fatal(1);
  end

endmodule
